// File: rtl/mips_instr_encoder.sv
// Symbolic-to-binary MIPS encoder feeding sequential program-memory writes.
// Each emitted word carries its word address; `li` may expand into lui + ori.
module mips_instr_encoder #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            mnemonic,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [4:0]            shamt,
    input  logic [31:0]           imm,
    input  logic [25:0]           target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_word,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  bad_mnemonic
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [4:0] MN_SLL   = 5'd0;
    localparam logic [4:0] MN_JR    = 5'd1;
    localparam logic [4:0] MN_MFLO  = 5'd2;
    localparam logic [4:0] MN_MULT  = 5'd3;
    localparam logic [4:0] MN_ADD   = 5'd4;
    localparam logic [4:0] MN_OR    = 5'd5;
    localparam logic [4:0] MN_SLT   = 5'd6;
    localparam logic [4:0] MN_J     = 5'd7;
    localparam logic [4:0] MN_JAL   = 5'd8;
    localparam logic [4:0] MN_BEQ   = 5'd9;
    localparam logic [4:0] MN_BNE   = 5'd10;
    localparam logic [4:0] MN_UCOPY = 5'd11;
    localparam logic [4:0] MN_ADDI  = 5'd12;
    localparam logic [4:0] MN_SLTI  = 5'd13;
    localparam logic [4:0] MN_ANDI  = 5'd14;
    localparam logic [4:0] MN_ORI   = 5'd15;
    localparam logic [4:0] MN_LUI   = 5'd16;
    localparam logic [4:0] MN_LW    = 5'd17;
    localparam logic [4:0] MN_SW    = 5'd18;
    localparam logic [4:0] MN_LI    = 5'd19;

    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_ORI = 6'h0D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]           word_q;
    logic [31:0]           second_q;
    logic                  pending_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  bad_q;

    logic [31:0] enc_word;
    logic [31:0] enc_word2;
    logic        enc_two;
    logic        enc_ok;

    logic load_first;
    logic load_second;
    logic advance;
    logic clear_addr;
    logic bad_next;

    function automatic logic [31:0] r_word(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                           input logic [4:0] f_rd, input logic [4:0] f_sh,
                                           input logic [5:0] funct);
        return {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] f_rs,
                                           input logic [4:0] f_rt, input logic [15:0] f_imm);
        return {op, f_rs, f_rt, f_imm};
    endfunction

    // Combinational encoder: fields that a format does not use are forced to zero.
    always_comb begin
        enc_word  = '0;
        enc_word2 = '0;
        enc_two   = 1'b0;
        enc_ok    = 1'b1;
        case (mnemonic)
            MN_SLL:   enc_word = r_word(5'd0, rt, rd, shamt, 6'h00);
            MN_JR:    enc_word = r_word(rs, 5'd0, 5'd0, 5'd0, 6'h08);
            MN_MFLO:  enc_word = r_word(5'd0, 5'd0, rd, 5'd0, 6'h12);
            MN_MULT:  enc_word = r_word(rs, rt, 5'd0, 5'd0, 6'h18);
            MN_ADD:   enc_word = r_word(rs, rt, rd, 5'd0, 6'h20);
            MN_OR:    enc_word = r_word(rs, rt, rd, 5'd0, 6'h25);
            MN_SLT:   enc_word = r_word(rs, rt, rd, 5'd0, 6'h2A);
            MN_J:     enc_word = {6'h02, target};
            MN_JAL:   enc_word = {6'h03, target};
            MN_BEQ:   enc_word = i_word(6'h04, rs, rt, imm[15:0]);
            MN_BNE:   enc_word = i_word(6'h05, rs, rt, imm[15:0]);
            MN_UCOPY: enc_word = i_word(6'h06, rs, rt, imm[15:0]);
            MN_ADDI:  enc_word = i_word(6'h08, rs, rt, imm[15:0]);
            MN_SLTI:  enc_word = i_word(6'h0A, rs, rt, imm[15:0]);
            MN_ANDI:  enc_word = i_word(6'h0C, rs, rt, imm[15:0]);
            MN_ORI:   enc_word = i_word(OP_ORI, rs, rt, imm[15:0]);
            MN_LUI:   enc_word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
            MN_LW:    enc_word = i_word(6'h23, rs, rt, imm[15:0]);
            MN_SW:    enc_word = i_word(6'h2B, rs, rt, imm[15:0]);
            MN_LI: begin
                if (imm[31:16] != 16'h0000) begin
                    enc_word  = i_word(OP_LUI, 5'd0, rt, imm[31:16]);
                    enc_word2 = i_word(OP_ORI, rt, rt, imm[15:0]);
                    enc_two   = 1'b1;
                end else begin
                    enc_word  = i_word(OP_ORI, 5'd0, rt, imm[15:0]);
                end
            end
            default:  enc_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_first  = 1'b0;
        load_second = 1'b0;
        advance     = 1'b0;
        clear_addr  = 1'b0;
        bad_next    = 1'b0;
        case (state)
            IDLE: begin
                clear_addr = clear;
                if (in_valid) begin
                    if (enc_ok) begin
                        load_first = 1'b1;
                        state_next = EMIT;
                    end else begin
                        bad_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    advance = 1'b1;
                    if (pending_q) begin
                        load_second = 1'b1;
                        state_next  = EMIT2;
                    end else begin
                        state_next  = IDLE;
                    end
                end
            end
            EMIT2: begin
                if (out_ready) begin
                    advance    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear only happens in IDLE and advance only outside it, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q    <= '0;
            second_q  <= '0;
            pending_q <= 1'b0;
            addr_q    <= BASE;
            bad_q     <= 1'b0;
        end else begin
            bad_q <= bad_next;
            if (clear_addr) begin
                addr_q <= BASE;
            end else if (advance) begin
                addr_q <= addr_q + 1'b1;
            end
            if (load_first) begin
                word_q    <= enc_word;
                second_q  <= enc_word2;
                pending_q <= enc_two;
            end else if (load_second) begin
                word_q    <= second_q;
                pending_q <= 1'b0;
            end
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state != IDLE);
    assign out_word     = word_q;
    assign out_addr     = addr_q;
    assign bad_mnemonic = bad_q;

endmodule
